// File: rtl/hyper_pkg.sv
// Shared types and widths for the hyper_arb request arbiter.
package hyper_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam int                WDOG_W     = 16;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF;
  localparam int                BE_W       = 4;
  localparam int                NDW_W      = 6;
endpackage

// File: rtl/hyper_rr_arb.sv
// Two-way round-robin grant; last_grant advances only when en_i accepts a request.
module hyper_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_o,
  output logic       vld_o
);
  logic last_q;

  always_comb begin
    vld_o = |req_i;
    if (&req_i) gnt_o = ~last_q;
    else        gnt_o = req_i[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               last_q <= 1'b1;
    else if (en_i && vld_o)  last_q <= gnt_o;
  end
endmodule

// File: rtl/hyper_arb.sv
// Two-port arbiter in front of hyper_xface: grants, issues one op, waits for busy to drop.
// Optional watchdog enabled by defining HYPER_ARB_TIMEOUT_EN.
module hyper_arb
  import hyper_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_rd_req,
  input  logic              p0_wr_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wr_d,
  input  logic [BE_W-1:0]   p0_wr_byte_en,
  input  logic [NDW_W-1:0]  p0_rd_num_dwords,
  output logic              p0_ack,
  output logic              p0_rd_valid,
  input  logic              p1_rd_req,
  input  logic              p1_wr_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wr_d,
  input  logic [BE_W-1:0]   p1_wr_byte_en,
  input  logic [NDW_W-1:0]  p1_rd_num_dwords,
  output logic              p1_ack,
  output logic              p1_rd_valid,
  output logic [DATA_W-1:0] rd_d,
  output logic              x_rd_req,
  output logic              x_wr_req,
  output logic [ADDR_W-1:0] x_addr,
  output logic [DATA_W-1:0] x_wr_d,
  output logic [BE_W-1:0]   x_wr_byte_en,
  output logic [NDW_W-1:0]  x_rd_num_dwords,
  input  logic              x_busy,
  input  logic [DATA_W-1:0] x_rd_d,
  output logic              err
);
  state_e            state_q;
  logic              port_q, is_wr_q;
  logic              p0_ack_q, p1_ack_q, p0_rd_valid_q, p1_rd_valid_q;
  logic              x_rd_req_q, x_wr_req_q, err_q;
  logic [ADDR_W-1:0] x_addr_q;
  logic [DATA_W-1:0] x_wr_d_q, rd_d_q;
  logic [BE_W-1:0]   x_be_q;
  logic [NDW_W-1:0]  x_ndw_q;

  logic [1:0] req;
  logic       gnt, gnt_vld, wdog_hit;

  assign req = {p1_rd_req | p1_wr_req, p0_rd_req | p0_wr_req};

  hyper_rr_arb u_rr (
    .clk   (clk),
    .reset (reset),
    .req_i (req),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt),
    .vld_o (gnt_vld)
  );

  // A port raising both rd and wr is served as a write.
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wr_d;
  logic [BE_W-1:0]   sel_be;
  logic [NDW_W-1:0]  sel_ndw;

  assign sel_wr   = gnt ? p1_wr_req        : p0_wr_req;
  assign sel_addr = gnt ? p1_addr          : p0_addr;
  assign sel_wr_d = gnt ? p1_wr_d          : p0_wr_d;
  assign sel_be   = gnt ? p1_wr_byte_en    : p0_wr_byte_en;
  assign sel_ndw  = gnt ? p1_rd_num_dwords : p0_rd_num_dwords;

`ifdef HYPER_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             wdog_q <= '0;
    else if (state_q == ISSUE)                             wdog_q <= '0;
    else if (state_q == WAIT_BUSY || state_q == WAIT_DONE) wdog_q <= wdog_q + WDOG_W'(1);
  end

  // Fires on the edge where the counter would reach the limit.
  assign wdog_hit = (state_q == WAIT_BUSY || state_q == WAIT_DONE) &&
                    (wdog_q == WDOG_LIMIT - WDOG_W'(1));
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      port_q        <= 1'b0;
      is_wr_q       <= 1'b0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p0_rd_valid_q <= 1'b0;
      p1_rd_valid_q <= 1'b0;
      x_rd_req_q    <= 1'b0;
      x_wr_req_q    <= 1'b0;
      err_q         <= 1'b0;
      x_addr_q      <= '0;
      x_wr_d_q      <= '0;
      x_be_q        <= 4'hF;
      x_ndw_q       <= '0;
      rd_d_q        <= '0;
    end else begin
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p0_rd_valid_q <= 1'b0;
      p1_rd_valid_q <= 1'b0;
      x_rd_req_q    <= 1'b0;
      x_wr_req_q    <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            port_q     <= gnt;
            is_wr_q    <= sel_wr;
            x_addr_q   <= sel_addr;
            x_wr_d_q   <= sel_wr_d;
            x_be_q     <= sel_be;
            x_ndw_q    <= sel_ndw;
            x_wr_req_q <= sel_wr;
            x_rd_req_q <= ~sel_wr;
            p0_ack_q   <= ~gnt;
            p1_ack_q   <= gnt;
            state_q    <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (wdog_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (x_busy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (wdog_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (!x_busy) begin
            state_q <= IDLE;
            if (!is_wr_q) begin
              rd_d_q        <= x_rd_d;
              p0_rd_valid_q <= ~port_q;
              p1_rd_valid_q <= port_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_ack          = p0_ack_q;
  assign p1_ack          = p1_ack_q;
  assign p0_rd_valid     = p0_rd_valid_q;
  assign p1_rd_valid     = p1_rd_valid_q;
  assign rd_d            = rd_d_q;
  assign x_rd_req        = x_rd_req_q;
  assign x_wr_req        = x_wr_req_q;
  assign x_addr          = x_addr_q;
  assign x_wr_d          = x_wr_d_q;
  assign x_wr_byte_en    = x_be_q;
  assign x_rd_num_dwords = x_ndw_q;
  assign err             = err_q;
endmodule

// File: tb/tb_hyper_arb.sv
// Directed bench for hyper_arb with an issue/read-data scoreboard and a hyper_xface responder.
module tb_hyper_arb;
  logic        clk, reset;
  logic        p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
  logic [31:0] p0_addr, p0_wr_d, p1_addr, p1_wr_d;
  logic [3:0]  p0_wr_byte_en, p1_wr_byte_en;
  logic [5:0]  p0_rd_num_dwords, p1_rd_num_dwords;
  logic        p0_ack, p0_rd_valid, p1_ack, p1_rd_valid;
  logic [31:0] rd_d, x_addr, x_wr_d, x_rd_d;
  logic        x_rd_req, x_wr_req, x_busy, err;
  logic [3:0]  x_wr_byte_en;
  logic [5:0]  x_rd_num_dwords;

  typedef struct {
    bit          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [5:0]  ndw;
  } exp_t;
  typedef struct {
    bit          port;
    logic [31:0] data;
  } rd_t;

  exp_t        exp_q[$];
  rd_t         rd_q[$];
  int          n_cmp, n_bad, cyc;
  bit          busy_stuck;
  logic [31:0] rd_data_next;

  hyper_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req), .p0_addr(p0_addr), .p0_wr_d(p0_wr_d),
    .p0_wr_byte_en(p0_wr_byte_en), .p0_rd_num_dwords(p0_rd_num_dwords),
    .p0_ack(p0_ack), .p0_rd_valid(p0_rd_valid),
    .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req), .p1_addr(p1_addr), .p1_wr_d(p1_wr_d),
    .p1_wr_byte_en(p1_wr_byte_en), .p1_rd_num_dwords(p1_rd_num_dwords),
    .p1_ack(p1_ack), .p1_rd_valid(p1_rd_valid),
    .rd_d(rd_d), .x_rd_req(x_rd_req), .x_wr_req(x_wr_req), .x_addr(x_addr), .x_wr_d(x_wr_d),
    .x_wr_byte_en(x_wr_byte_en), .x_rd_num_dwords(x_rd_num_dwords),
    .x_busy(x_busy), .x_rd_d(x_rd_d), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bump_fail(string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s observed=missing/unexpected event expected=scoreboard event", tag);
  endtask

  // hyper_xface model: busy for three cycles after each issue pulse.
  initial begin
    int cnt;
    cnt = 0; x_busy = 1'b0; x_rd_d = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        x_busy = 1'b0; cnt = 0;
      end else if (busy_stuck) begin
        x_busy = 1'b1;
      end else if (x_rd_req || x_wr_req) begin
        x_busy = 1'b1; cnt = 3; x_rd_d = rd_data_next;
      end else if (cnt > 1) begin
        cnt--;
      end else begin
        cnt = 0; x_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: checks each issue and each read-data return.
  initial begin
    bit   prev_busy, outstanding;
    exp_t e;
    rd_t  r;
    prev_busy = 1'b0; outstanding = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_busy = 1'b0; outstanding = 1'b0;
      end else begin
        if (prev_busy && !x_busy) outstanding = 1'b0;
        prev_busy = x_busy;
        if (x_rd_req || x_wr_req) begin
          chk("issue_onehot", x_rd_req && x_wr_req, 0);
          chk("issue_after_busy_fall", outstanding, 0);
          outstanding = 1'b1;
          if (exp_q.size() == 0) bump_fail("issue_unexpected");
          else begin
            e = exp_q.pop_front();
            chk("issue_p0_ack", p0_ack, !e.port);
            chk("issue_p1_ack", p1_ack, e.port);
            chk("issue_is_wr", x_wr_req, e.wr);
            chk("issue_addr", x_addr, e.addr);
            chk("issue_be", x_wr_byte_en, e.be);
            if (e.wr) chk("issue_wr_d", x_wr_d, e.data);
            else      chk("issue_ndw", x_rd_num_dwords, e.ndw);
          end
        end else if (p0_ack || p1_ack) begin
          bump_fail("ack_without_issue");
        end
        if (p0_rd_valid || p1_rd_valid) begin
          if (rd_q.size() == 0) bump_fail("rd_valid_unexpected");
          else begin
            r = rd_q.pop_front();
            chk("rdv_p0", p0_rd_valid, !r.port);
            chk("rdv_p1", p1_rd_valid, r.port);
            chk("rdv_data", rd_d, r.data);
          end
        end
      end
    end
  end

  task automatic drive(int port, bit rd, bit wr, logic [31:0] a, logic [31:0] d,
                       logic [3:0] be, logic [5:0] n);
    if (port == 0) begin
      p0_rd_req = rd; p0_wr_req = wr; p0_addr = a; p0_wr_d = d;
      p0_wr_byte_en = be; p0_rd_num_dwords = n;
    end else begin
      p1_rd_req = rd; p1_wr_req = wr; p1_addr = a; p1_wr_d = d;
      p1_wr_byte_en = be; p1_rd_num_dwords = n;
    end
  endtask

  task automatic push(bit port, bit wr, logic [31:0] a, logic [31:0] d,
                      logic [3:0] be, logic [5:0] n);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = a; e.data = d; e.be = be; e.ndw = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(int port, string tag);
    int  i;
    bit  seen;
    i = 0; seen = 1'b0;
    while (!seen && i < 100) begin
      @(negedge clk);
      i++;
      seen = (port == 0) ? p0_ack : p1_ack;
    end
    if (!seen) bump_fail(tag);
    if (port == 0) begin p0_rd_req = 1'b0; p0_wr_req = 1'b0; end
    else           begin p1_rd_req = 1'b0; p1_wr_req = 1'b0; end
  endtask

  task automatic drain(string tag);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0 || x_busy) && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0 || rd_q.size() != 0 || x_busy) bump_fail(tag);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_vals(string pfx);
    chk({pfx, "_x_rd_req"}, x_rd_req, 0);
    chk({pfx, "_x_wr_req"}, x_wr_req, 0);
    chk({pfx, "_p0_ack"}, p0_ack, 0);
    chk({pfx, "_p1_ack"}, p1_ack, 0);
    chk({pfx, "_p0_rdv"}, p0_rd_valid, 0);
    chk({pfx, "_p1_rdv"}, p1_rd_valid, 0);
    chk({pfx, "_err"}, err, 0);
    chk({pfx, "_x_addr"}, x_addr, 0);
    chk({pfx, "_x_wr_d"}, x_wr_d, 0);
    chk({pfx, "_x_be"}, x_wr_byte_en, 4'hF);
    chk({pfx, "_x_ndw"}, x_rd_num_dwords, 0);
    chk({pfx, "_rd_d"}, rd_d, 0);
  endtask

  initial begin
    int n0, n1, guard, t_issue;
    n_cmp = 0; n_bad = 0; busy_stuck = 1'b0; rd_data_next = 32'h0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 4'h0, 0);
    drive(1, 0, 0, 0, 0, 4'h0, 0);
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    // Single port-0 write: issue and ack one cycle after the request is seen.
    push(0, 1, 32'h012345, 32'h012345, 4'hF, 6'd0);
    drive(0, 0, 1, 32'h012345, 32'h012345, 4'hF, 6'd0);
    @(negedge clk);
    chk("t1_wr_req_latency", x_wr_req, 1);
    chk("t1_ack_latency", p0_ack, 1);
    p0_wr_req = 1'b0;
    @(negedge clk);
    chk("t1_wr_req_one_cycle", x_wr_req, 0);
    chk("t1_ack_one_cycle", p0_ack, 0);
    drain("t1_drain_timeout");

    // Port-1 read returning DEADBEEF.
    rd_data_next = 32'hDEADBEEF;
    push(1, 0, 32'h6789AB, 32'h0, 4'h3, 6'd4);
    rd_q.push_back('{port: 1'b1, data: 32'hDEADBEEF});
    drive(1, 1, 0, 32'h6789AB, 32'h0, 4'h3, 6'd4);
    wait_ack(1, "t2_ack_timeout");
    drain("t2_drain_timeout");
    chk("t2_rd_d_held", rd_d, 32'hDEADBEEF);
    chk("t2_p1_rdv_low", p1_rd_valid, 0);

    // Both ports write three times each: strict alternation starting with port 0.
    for (int k = 0; k < 3; k++) begin
      push(0, 1, 32'h100 + k, 32'hA000_0000 + k, 4'h1, 6'd0);
      push(1, 1, 32'h200 + k, 32'hB000_0000 + k, 4'h8, 6'd0);
    end
    drive(0, 0, 1, 32'h100, 32'hA000_0000, 4'h1, 6'd0);
    drive(1, 0, 1, 32'h200, 32'hB000_0000, 4'h8, 6'd0);
    n0 = 0; n1 = 0; guard = 0;
    while ((n0 < 3 || n1 < 3) && guard < 300) begin
      @(negedge clk);
      guard++;
      if (p0_ack) begin
        n0++;
        if (n0 < 3) drive(0, 0, 1, 32'h100 + n0, 32'hA000_0000 + n0, 4'h1, 6'd0);
        else        p0_wr_req = 1'b0;
      end
      if (p1_ack) begin
        n1++;
        if (n1 < 3) drive(1, 0, 1, 32'h200 + n1, 32'hB000_0000 + n1, 4'h8, 6'd0);
        else        p1_wr_req = 1'b0;
      end
    end
    if (n0 < 3 || n1 < 3) bump_fail("t3_pair_timeout");
    drain("t3_drain_timeout");

    // Port 0 with rd and wr together is issued as a write.
    push(0, 1, 32'h3C3C, 32'h5A5A_A5A5, 4'h6, 6'd9);
    drive(0, 1, 1, 32'h3C3C, 32'h5A5A_A5A5, 4'h6, 6'd9);
    wait_ack(0, "t4_ack_timeout");
    drain("t4_drain_timeout");

    // Asynchronous reset while waiting for busy to drop.
    push(0, 1, 32'h55AA, 32'h1111_2222, 4'hC, 6'd0);
    drive(0, 0, 1, 32'h55AA, 32'h1111_2222, 4'hC, 6'd0);
    wait_ack(0, "t5_ack_timeout");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push(1, 1, 32'h7777, 32'h8888_9999, 4'hF, 6'd0);
    drive(1, 0, 1, 32'h7777, 32'h8888_9999, 4'hF, 6'd0);
    @(negedge clk);
    chk("t5_post_reset_wr_req", x_wr_req, 1);
    chk("t5_post_reset_ack", p1_ack, 1);
    p1_wr_req = 1'b0;
    drain("t5_drain_timeout");

`ifdef HYPER_ARB_TIMEOUT_EN
    // Busy stuck high: err after the watchdog limit, then the pending port-1 write proceeds.
    busy_stuck = 1'b1;
    push(0, 0, 32'hBAD0, 32'h0, 4'hF, 6'd2);
    push(1, 1, 32'hCAFE, 32'hFEED_F00D, 4'hF, 6'd0);
    drive(0, 1, 0, 32'hBAD0, 32'h0, 4'hF, 6'd2);
    wait_ack(0, "t6_ack_timeout");
    t_issue = cyc;
    drive(1, 0, 1, 32'hCAFE, 32'hFEED_F00D, 4'hF, 6'd0);
    guard = 0;
    while (!err && guard < 70000) begin
      @(posedge clk);
      #1 guard++;
    end
    busy_stuck = 1'b0;
    if (!err) bump_fail("t6_err_timeout");
    else begin
      // Counter hits FFFF on the edge closing wait cycle 65535; err shows the cycle after.
      chk("t6_err_delay", cyc - t_issue, 65536);
      @(posedge clk);
      #1 chk("t6_err_one_cycle", err, 0);
    end
    wait_ack(1, "t6_pending_ack_timeout");
    drain("t6_drain_timeout");
`else
    t_issue = 0;
    chk("no_watchdog_err", err, t_issue[0]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
